// File: rtl/biker_collision_detector_pkg.sv
// collision_pkg: shared types and constants for the biker collision detector.
// Holds the FSM state type, hit-edge encoding and counter width helper.
package collision_pkg;

  typedef enum logic {
    ARMED    = 1'b0,
    COOLDOWN = 1'b1
  } collision_state_t;

  typedef logic [3:0] hit_edge_t;

  localparam hit_edge_t EDGE_TOP    = 4'b1000;
  localparam hit_edge_t EDGE_LEFT   = 4'b0100;
  localparam hit_edge_t EDGE_RIGHT  = 4'b0010;
  localparam hit_edge_t EDGE_BOTTOM = 4'b0001;
  localparam hit_edge_t EDGE_ALL    =
    EDGE_TOP | EDGE_LEFT | EDGE_RIGHT | EDGE_BOTTOM;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/biker_collision_detector_if.sv
// biker_collision_detector_if: draw-layer inputs and game-logic outputs.
// master = draw layer / game logic side, slave = detector.
interface biker_collision_detector_if #(
  parameter int NUM_OBSTACLES = 4
);
  import collision_pkg::*;

  logic                     startOfFrame;
  logic                     bikerDrawingRequest;
  hit_edge_t                bikerHitEdgeCode;
  logic [NUM_OBSTACLES-1:0] obstacleDrawingRequest;
  logic                     collision;
  hit_edge_t                collisionEdgeCode;
  logic [NUM_OBSTACLES-1:0] collisionSource;
  logic                     cooldownActive;
  logic                     bikerVisible;

  modport master (
    output startOfFrame,
    output bikerDrawingRequest,
    output bikerHitEdgeCode,
    output obstacleDrawingRequest,
    input  collision,
    input  collisionEdgeCode,
    input  collisionSource,
    input  cooldownActive,
    input  bikerVisible
  );

  modport slave (
    input  startOfFrame,
    input  bikerDrawingRequest,
    input  bikerHitEdgeCode,
    input  obstacleDrawingRequest,
    output collision,
    output collisionEdgeCode,
    output collisionSource,
    output cooldownActive,
    output bikerVisible
  );

endinterface

// File: rtl/biker_collision_detector_frame_down_counter.sv
// frame_down_counter: loadable down-counter stepped once per enabled frame.
// Saturates at zero and flags it; load wins over decrement.
module frame_down_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/biker_collision_detector.sv
// biker_collision_detector: reports one overlap event per frame, then cooldown.
// Optional biker flicker during cooldown: define BIKER_COLLISION_FLICKER_EN.
module biker_collision_detector
  import collision_pkg::*;
#(
  parameter int NUM_OBSTACLES   = 4,
  parameter int COOLDOWN_FRAMES = 60,
  parameter int FLICKER_PERIOD  = 4
) (
  input logic clk,
  input logic resetN,
  biker_collision_detector_if.slave bus
);

  localparam int CW = cnt_w(COOLDOWN_FRAMES + 1);
  localparam logic [CW-1:0] CD_RELOAD =
    CW'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);

  collision_state_t         r_state;
  collision_state_t         w_next;
  logic                     r_hit;
  logic                     r_collision;
  hit_edge_t                r_edge_acc;
  hit_edge_t                r_edge;
  logic [NUM_OBSTACLES-1:0] r_src_acc;
  logic [NUM_OBSTACLES-1:0] r_src;
  logic                     w_sof;
  logic                     w_overlap;
  logic                     w_report;
  logic                     w_enter_cd;
  logic                     w_cd_tick;
  logic                     w_cd_zero;
  logic                     w_acc_en;
  hit_edge_t                w_code;

  assign w_sof     = bus.startOfFrame;
  assign w_code    = bus.bikerHitEdgeCode & EDGE_ALL;
  assign w_overlap = bus.bikerDrawingRequest &&
                     (|bus.obstacleDrawingRequest);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= ARMED;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ARMED:
        if (w_sof && r_hit && (COOLDOWN_FRAMES > 0))
          w_next = COOLDOWN;
      COOLDOWN:
        if (w_sof && w_cd_zero)
          w_next = ARMED;
    endcase
  end

  always_comb begin
    w_report   = 1'b0;
    w_enter_cd = 1'b0;
    w_cd_tick  = 1'b0;
    unique case (r_state)
      ARMED: begin
        w_report   = w_sof && r_hit;
        w_enter_cd = (w_next == COOLDOWN);
      end
      COOLDOWN: w_cd_tick = w_sof;
    endcase
    // An overlap on a frame-start cycle belongs to the frame it opens
    w_acc_en = w_overlap && (w_next == ARMED);
  end

  frame_down_counter #(.W(CW)) u_cooldown (
    .clk       (clk),
    .rst_n     (resetN),
    .i_en      (w_cd_tick),
    .i_load    (w_enter_cd),
    .i_load_val(CD_RELOAD),
    .o_zero    (w_cd_zero)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hit      <= 1'b0;
      r_edge_acc <= '0;
      r_src_acc  <= '0;
    end else if (w_sof) begin
      r_hit      <= w_acc_en;
      r_edge_acc <= w_acc_en ? w_code : '0;
      r_src_acc  <= w_acc_en ? bus.obstacleDrawingRequest : '0;
    end else if (w_acc_en) begin
      r_hit      <= 1'b1;
      r_edge_acc <= r_edge_acc | w_code;
      r_src_acc  <= r_src_acc | bus.obstacleDrawingRequest;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_collision <= 1'b0;
      r_edge      <= '0;
      r_src       <= '0;
    end else begin
      r_collision <= w_report;
      if (w_report) begin
        r_edge <= r_edge_acc;
        r_src  <= r_src_acc;
      end
    end
  end

  assign bus.collision         = r_collision;
  assign bus.collisionEdgeCode = r_edge;
  assign bus.collisionSource   = r_src;
  assign bus.cooldownActive    = (r_state == COOLDOWN);

`ifdef BIKER_COLLISION_FLICKER_EN
  localparam int FW = cnt_w(FLICKER_PERIOD);
  localparam logic [FW-1:0] FL_RELOAD = FW'(FLICKER_PERIOD - 1);

  logic r_visible;
  logic w_fl_tick;
  logic w_fl_zero;

  assign w_fl_tick = w_cd_tick && (w_next == COOLDOWN);

  frame_down_counter #(.W(FW)) u_flicker (
    .clk       (clk),
    .rst_n     (resetN),
    .i_en      (w_fl_tick),
    .i_load    (w_enter_cd || (w_fl_tick && w_fl_zero)),
    .i_load_val(FL_RELOAD),
    .o_zero    (w_fl_zero)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                   r_visible <= 1'b1;
    else if (w_enter_cd)           r_visible <= 1'b0;
    else if (w_next == ARMED)      r_visible <= 1'b1;
    else if (w_fl_tick && w_fl_zero) r_visible <= ~r_visible;
  end

  assign bus.bikerVisible = r_visible;
`else
  assign bus.bikerVisible = (FLICKER_PERIOD > 0) || 1'b1;
`endif

endmodule

// File: tb/tb_biker_collision_detector.sv
// tb_biker_collision_detector: directed + random frames vs a frame-level model.
// Model tracks remaining cooldown frames and per-frame OR of overlaps.
`timescale 1ns/1ps
module tb_biker_collision_detector;
  import collision_pkg::*;

  localparam int NO = 4;
  localparam int CD = 3;
  localparam int FP = 2;

  typedef struct packed {
    logic          b;
    logic [3:0]    c;
    logic [NO-1:0] o;
  } px_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  biker_collision_detector_if #(.NUM_OBSTACLES(NO)) bus();

  biker_collision_detector #(
    .NUM_OBSTACLES  (NO),
    .COOLDOWN_FRAMES(CD),
    .FLICKER_PERIOD (FP)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  px_t           fq[$];
  int            m_cool;
  logic          m_hit;
  logic [3:0]    m_e;
  logic [NO-1:0] m_s;
  logic [3:0]    x_edge;
  logic [NO-1:0] x_src;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_vis();
`ifdef BIKER_COLLISION_FLICKER_EN
    if (m_cool > 0) return (((CD - m_cool) / FP) % 2) == 1;
`endif
    return 1'b1;
  endfunction

  task automatic check_outs(input logic pulse);
    chk("collision", bus.collision, pulse);
    chk("edge", bus.collisionEdgeCode, x_edge);
    chk("source", bus.collisionSource, x_src);
    chk("cooldown", bus.cooldownActive, m_cool > 0);
    chk("visible", bus.bikerVisible, exp_vis());
  endtask

  task automatic model_reset();
    m_cool = 0;
    m_hit  = 1'b0;
    m_e    = '0;
    m_s    = '0;
    x_edge = '0;
    x_src  = '0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    #1;
    model_reset();
    check_outs(1'b0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic new_frame(input int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back('0);
  endtask

  task automatic set_px(input int i, input logic b,
                        input logic [3:0] c, input logic [NO-1:0] o);
    fq[i].b = b;
    fq[i].c = c;
    fq[i].o = o;
  endtask

  task automatic run_frame(input int rst_at);
    for (int i = 0; i < fq.size(); i++) begin
      logic pulse;
      logic ov;
      if (i == rst_at) do_reset();
      bus.startOfFrame           = (i == 0);
      bus.bikerDrawingRequest    = fq[i].b;
      bus.bikerHitEdgeCode       = fq[i].c;
      bus.obstacleDrawingRequest = fq[i].o;
      @(posedge clk);
      @(negedge clk);
      ov    = fq[i].b && (|fq[i].o);
      pulse = 1'b0;
      if (i == 0) begin
        if (m_cool == 0 && m_hit) begin
          pulse  = 1'b1;
          x_edge = m_e;
          x_src  = m_s;
        end
        if (pulse && CD > 0) m_cool = CD;
        else if (m_cool > 0) m_cool--;
        m_hit = 1'b0;
        m_e   = '0;
        m_s   = '0;
      end
      if (m_cool == 0 && ov) begin
        m_hit = 1'b1;
        m_e   = m_e | fq[i].c;
        m_s   = m_s | fq[i].o;
      end
      check_outs(pulse);
    end
  endtask

  initial begin
    bus.startOfFrame           = 1'b0;
    bus.bikerDrawingRequest    = 1'b0;
    bus.bikerHitEdgeCode       = '0;
    bus.obstacleDrawingRequest = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outs(1'b0);
    resetN = 1'b1;
    @(negedge clk);

    new_frame(6);
    run_frame(-1);
    new_frame(6);
    set_px(3, 1'b1, EDGE_TOP, 4'b0010);
    run_frame(-1);
    for (int f = 0; f < 7; f++) begin
      new_frame(5);
      set_px(2, 1'b1, EDGE_BOTTOM, 4'b0001);
      run_frame(-1);
    end

    new_frame(8);
    set_px(1, 1'b1, EDGE_BOTTOM, 4'b0001);
    set_px(3, 1'b0, EDGE_RIGHT, 4'b0100);
    set_px(4, 1'b1, EDGE_RIGHT, 4'b0000);
    set_px(5, 1'b1, EDGE_LEFT, 4'b1000);
    run_frame(-1);
    for (int f = 0; f < 4; f++) begin
      new_frame(5);
      run_frame(-1);
    end

    new_frame(5);
    set_px(0, 1'b1, EDGE_RIGHT, 4'b0100);
    run_frame(-1);
    new_frame(5);
    run_frame(-1);
    new_frame(5);
    run_frame(6);
    new_frame(6);
    run_frame(3);
    new_frame(5);
    set_px(2, 1'b1, 4'h0, 4'b0001);
    run_frame(-1);
    new_frame(5);
    run_frame(-1);

    for (int f = 0; f < 80; f++) begin
      int  n;
      bit  busy;
      n    = $urandom_range(3, 10);
      busy = ($urandom_range(0, 2) != 0);
      new_frame(n);
      for (int i = 0; i < n; i++) begin
        logic          b;
        logic [3:0]    c;
        logic [NO-1:0] o;
        b = busy && ($urandom_range(0, 2) == 0);
        c = 4'($urandom);
        o = ($urandom_range(0, 1) == 1) ? NO'($urandom) : '0;
        set_px(i, b, c, o);
      end
      run_frame((f % 17 == 9) ? int'($urandom_range(1, n - 1)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
